// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU select codes and the sequencer state encoding.
// Later multi-cycle units reuse the same states.
package riscv_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Core-side request/response and shared-ALU borrow signals of the multiply sequencer.
// The slave modport is the sequencer; the master modport is the execute stage.
interface alu_mul_sequencer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  Start;
  logic                  Flush;
  logic                  Mul_Hi;
  logic [DATA_WIDTH-1:0] Op_A;
  logic [DATA_WIDTH-1:0] Op_B;
  logic [DATA_WIDTH-1:0] ALU_Result;
  logic                  Alu_Own;
  logic [DATA_WIDTH-1:0] Alu_Src_A;
  logic [DATA_WIDTH-1:0] Alu_Src_B;
  logic [3:0]            Alu_Sel;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Product;

  modport slave (
    input  Start, Flush, Mul_Hi, Op_A, Op_B, ALU_Result,
    output Alu_Own, Alu_Src_A, Alu_Src_B, Alu_Sel, Busy, Done, Product
  );

  modport master (
    output Start, Flush, Mul_Hi, Op_A, Op_B, ALU_Result,
    input  Alu_Own, Alu_Src_A, Alu_Src_B, Alu_Sel, Busy, Done, Product
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the core's combinational ALU in ADD mode,
// one partial product per cycle, and returns the low or high product word.
module alu_mul_sequencer
  import riscv_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_mul_sequencer_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH);

  seq_state_e            state_q;
  logic [DATA_WIDTH-1:0] acc_hi_q;
  logic [DATA_WIDTH-1:0] acc_lo_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] product_q;
  logic [CW-1:0]         cnt_q;
  logic                  hi_sel_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  running;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  carry;
  logic [DATA_WIDTH-1:0] acc_hi_d;
  logic [DATA_WIDTH-1:0] acc_lo_d;

  // ALU operands depend only on state and registers, never on ALU_Result.
  always_comb begin
    running  = (state_q == SEQ_RUN);
    src_a    = running ? acc_hi_q : '0;
    src_b    = (running && acc_lo_q[0]) ? mcand_q : '0;
    carry    = (bus.ALU_Result < src_a);
    acc_hi_d = {carry, bus.ALU_Result[DATA_WIDTH-1:1]};
    acc_lo_d = {bus.ALU_Result[0], acc_lo_q[DATA_WIDTH-1:1]};
  end

  assign bus.Alu_Own   = running;
  assign bus.Alu_Src_A = src_a;
  assign bus.Alu_Src_B = src_b;
  assign bus.Alu_Sel   = ALU_ADD;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Product   = product_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEQ_IDLE;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      hi_sel_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.Flush) begin
      state_q <= SEQ_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (bus.Start) begin
            acc_hi_q <= '0;
            acc_lo_q <= bus.Op_B;
            mcand_q  <= bus.Op_A;
            hi_sel_q <= bus.Mul_Hi;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          // Latch the final word together with the last step so Product is valid with Done.
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            product_q <= hi_sel_q ? acc_hi_d : acc_lo_d;
            done_q    <= 1'b1;
            state_q   <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= SEQ_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a delayed shared-ALU model and operand mux.
module tb_alu_mul_sequencer;
  import riscv_alu_pkg::*;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_mul_sequencer_if #(.DATA_WIDTH(W)) bus ();

  alu_mul_sequencer #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #250 clk = ~clk;

  // Shared ALU: the core would drive its own operands when the sequencer does not own it.
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  assign alu_a = bus.Alu_Own ? bus.Alu_Src_A : '0;
  assign alu_b = bus.Alu_Own ? bus.Alu_Src_B : '0;
  assign #50 bus.ALU_Result = (bus.Alu_Sel == ALU_SUB) ? (alu_a - alu_b) :
                              (bus.Alu_Sel == ALU_OR)  ? (alu_a | alu_b) :
                              (bus.Alu_Sel == ALU_AND) ? (alu_a & alu_b) :
                                                         (alu_a + alu_b);

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one multiply from an IDLE cycle and follows it to Done plus one cycle.
  task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic hi, input logic [W-1:0] exp);
    int   cyc;
    logic busy_ok;
    logic [W-1:0] exp_b;
    exp_b = b[0] ? a : '0;
    bus.Op_A   = a;
    bus.Op_B   = b;
    bus.Mul_Hi = hi;
    bus.Start  = 1'b1;
    step();
    bus.Start  = 1'b0;
    bus.Op_A   = $urandom;
    bus.Op_B   = $urandom;
    bus.Mul_Hi = ~hi;
    chk({tag, " own"}, 64'(bus.Alu_Own), 64'd1);
    chk({tag, " srcA0"}, 64'(bus.Alu_Src_A), 64'd0);
    chk({tag, " srcB0"}, 64'(bus.Alu_Src_B), 64'(exp_b));
    cyc     = 1;
    busy_ok = 1'b1;
    while (!bus.Done && cyc < 100) begin
      busy_ok &= bus.Busy;
      step();
      cyc++;
    end
    busy_ok &= bus.Busy;
    chk({tag, " latency"}, 64'(cyc), 64'(W + 1));
    chk({tag, " product"}, 64'(bus.Product), 64'(exp));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    step();
    chk({tag, " idle"}, 64'({bus.Busy, bus.Done, bus.Alu_Own}), 64'd0);
  endtask

  initial begin : main
    int   t;
    int   t0;
    logic done_seen;

    bus.Start  = 1'b0;
    bus.Flush  = 1'b0;
    bus.Mul_Hi = 1'b0;
    bus.Op_A   = '0;
    bus.Op_B   = '0;
    rst_n      = 1'b0;
    step();
    step();
    chk("rst busy", 64'(bus.Busy), 64'd0);
    chk("rst done", 64'(bus.Done), 64'd0);
    chk("rst product", 64'(bus.Product), 64'd0);
    chk("rst alu", 64'({bus.Alu_Own, bus.Alu_Sel, bus.Alu_Src_A, bus.Alu_Src_B}), 64'd0);
    rst_n = 1'b1;
    step();

    mul("3x5 lo", 32'd3, 32'd5, 1'b0, 32'h0000_000F);
    mul("max lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001);
    mul("max hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    mul("mix hi", 32'h8000_0000, 32'd2, 1'b1, 32'h0000_0001);
    mul("mix lo", 32'h8000_0000, 32'd2, 1'b0, 32'h0000_0000);

    // Start held high throughout: one accepted request per DATA_WIDTH+2 cycles.
    bus.Op_A   = 32'd10;
    bus.Op_B   = 32'd20;
    bus.Mul_Hi = 1'b0;
    bus.Start  = 1'b1;
    step();
    t = 1;
    while (!bus.Done && t < 100) begin
      bus.Op_A = $urandom;
      bus.Op_B = $urandom;
      step();
      t++;
    end
    chk("b2b first latency", 64'(t), 64'(W + 1));
    chk("b2b first product", 64'(bus.Product), 64'd200);
    t0 = t;
    bus.Op_A = 32'd11;
    bus.Op_B = 32'd3;
    step();
    t++;
    chk("b2b gap busy", 64'(bus.Busy), 64'd0);
    while (!bus.Done && t < t0 + 100) begin
      if (bus.Busy) begin
        bus.Op_A = $urandom;
        bus.Op_B = $urandom;
      end
      step();
      t++;
    end
    bus.Start = 1'b0;
    chk("b2b interval", 64'(t - t0), 64'(W + 2));
    chk("b2b second product", 64'(bus.Product), 64'd33);
    step();
    step();
    chk("b2b no restart", 64'({bus.Busy, bus.Done}), 64'd0);

    // Flush in RUN cycle 10.
    bus.Op_A   = 32'h1234;
    bus.Op_B   = 32'h10;
    bus.Mul_Hi = 1'b0;
    bus.Start  = 1'b1;
    step();
    bus.Start = 1'b0;
    repeat (9) step();
    bus.Flush = 1'b1;
    step();
    bus.Flush = 1'b0;
    chk("flush busy", 64'(bus.Busy), 64'd0);
    chk("flush own", 64'(bus.Alu_Own), 64'd0);
    chk("flush product", 64'(bus.Product), 64'd33);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      done_seen |= bus.Done;
      step();
    end
    chk("flush no done", 64'(done_seen), 64'd0);
    chk("flush product held", 64'(bus.Product), 64'd33);
    mul("7x6 after flush", 32'd7, 32'd6, 1'b0, 32'd42);

    // Asynchronous reset in RUN cycle 20.
    bus.Op_A   = 32'hAAAA;
    bus.Op_B   = 32'd3;
    bus.Mul_Hi = 1'b0;
    bus.Start  = 1'b1;
    step();
    bus.Start = 1'b0;
    repeat (19) step();
    #100;
    rst_n = 1'b0;
    #1;
    chk("arst busy", 64'(bus.Busy), 64'd0);
    chk("arst done", 64'(bus.Done), 64'd0);
    chk("arst product", 64'(bus.Product), 64'd0);
    chk("arst alu", 64'({bus.Alu_Own, bus.Alu_Sel, bus.Alu_Src_A, bus.Alu_Src_B}), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst stays idle", 64'({bus.Busy, bus.Done}), 64'd0);
    mul("0xmax after rst", 32'd0, 32'hFFFF_FFFF, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
